// File: rtl/sync_fifo_pkg.sv
// Shared helpers for the single-clock FIFO: width math, threshold legality and
// the status-word bit layout used by the register wrapper.
package sync_fifo_pkg;

    localparam int FLAG_EMPTY  = 0;
    localparam int FLAG_AEMPTY = 1;
    localparam int FLAG_AFULL  = 2;
    localparam int FLAG_FULL   = 3;
    localparam int FLAG_OVF    = 4;
    localparam int FLAG_UDF    = 5;
    localparam int FLAG_W      = 6;

    function automatic int clog2(input int value);
        int r;
        int v;
        r = 0;
        v = value - 1;
        while (v > 0) begin
            r++;
            v = v >> 1;
        end
        return r;
    endfunction

    function automatic bit thresholds_legal(input int depth, input int aempty_t, input int afull_t);
        return (aempty_t > 0) && (aempty_t < afull_t) && (afull_t <= depth);
    endfunction

endpackage

// File: rtl/fifo_ram.sv
// Dual-port storage: clocked write port, combinational read by address.
module fifo_ram #(
    parameter int addr_size  = 4,
    parameter int word_width = 8
) (
    input  logic                  clk,
    input  logic                  we,
    input  logic [addr_size-1:0]  waddr,
    input  logic [word_width-1:0] wdata,
    input  logic [addr_size-1:0]  raddr,
    output logic [word_width-1:0] rdata
);

    logic [word_width-1:0] mem [2**addr_size];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/sync_fifo_ctrl.sv
// Single-clock FIFO controller: pointers, occupancy, registered status flags,
// registered read port with valid strobe and sticky overflow/underflow.
module sync_fifo_ctrl
    import sync_fifo_pkg::*;
#(
    parameter int addr_size     = 4,
    parameter int word_width    = 8,
    parameter int afull_thresh  = 2**addr_size - 2,
    parameter int aempty_thresh = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  wr_en,
    input  logic [word_width-1:0] data_w,
    input  logic                  rd_en,
    output logic [word_width-1:0] data_r,
    output logic                  data_r_valid,
    output logic                  full,
    output logic                  empty,
    output logic                  almost_full,
    output logic                  almost_empty,
    output logic [addr_size:0]    count,
    output logic                  overflow,
    output logic                  underflow,
    input  logic                  clr_err
);

    localparam int DEPTH = 2**addr_size;
    localparam logic [addr_size:0] DEPTH_C  = (addr_size+1)'(DEPTH);
    localparam logic [addr_size:0] AFULL_C  = (addr_size+1)'(afull_thresh);
    localparam logic [addr_size:0] AEMPTY_C = (addr_size+1)'(aempty_thresh);

    if (!thresholds_legal(DEPTH, aempty_thresh, afull_thresh)) begin : g_bad_thresh
        $error("sync_fifo_ctrl: illegal almost-empty/almost-full thresholds");
    end

    logic [addr_size-1:0]  wr_ptr_q, wr_ptr_d;
    logic [addr_size-1:0]  rd_ptr_q, rd_ptr_d;
    logic [addr_size:0]    count_q, count_d;
    logic                  full_q, full_d;
    logic                  empty_q, empty_d;
    logic                  afull_q, afull_d;
    logic                  aempty_q, aempty_d;
    logic [word_width-1:0] data_r_q, data_r_d;
    logic                  valid_q, valid_d;
    logic                  ovf_q, ovf_d;
    logic                  udf_q, udf_d;
    logic [word_width-1:0] ram_rdata;
    logic                  wr_ok, rd_ok;

    // Accept decisions use the registered flags, so a full FIFO can still pop
    // while rejecting the same-cycle push (and vice versa when empty).
    assign wr_ok = wr_en & ~full_q;
    assign rd_ok = rd_en & ~empty_q;

    fifo_ram #(
        .addr_size  (addr_size),
        .word_width (word_width)
    ) u_ram (
        .clk   (clk),
        .we    (wr_ok),
        .waddr (wr_ptr_q),
        .wdata (data_w),
        .raddr (rd_ptr_q),
        .rdata (ram_rdata)
    );

    always_comb begin
        wr_ptr_d = wr_ok ? wr_ptr_q + 1'b1 : wr_ptr_q;
        rd_ptr_d = rd_ok ? rd_ptr_q + 1'b1 : rd_ptr_q;

        count_d = count_q;
        if (wr_ok && !rd_ok) begin
            count_d = count_q + 1'b1;
        end else if (rd_ok && !wr_ok) begin
            count_d = count_q - 1'b1;
        end

        // Flags come from the next count so they line up with count itself.
        full_d   = (count_d == DEPTH_C);
        empty_d  = (count_d == '0);
        afull_d  = (count_d >= AFULL_C);
        aempty_d = (count_d <= AEMPTY_C);

        data_r_d = rd_ok ? ram_rdata : data_r_q;
        valid_d  = rd_ok;

        ovf_d = (ovf_q & ~clr_err) | (wr_en & full_q);
        udf_d = (udf_q & ~clr_err) | (rd_en & empty_q);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            full_q   <= 1'b0;
            empty_q  <= 1'b1;
            afull_q  <= 1'b0;
            aempty_q <= 1'b1;
            data_r_q <= '0;
            valid_q  <= 1'b0;
            ovf_q    <= 1'b0;
            udf_q    <= 1'b0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            full_q   <= full_d;
            empty_q  <= empty_d;
            afull_q  <= afull_d;
            aempty_q <= aempty_d;
            data_r_q <= data_r_d;
            valid_q  <= valid_d;
            ovf_q    <= ovf_d;
            udf_q    <= udf_d;
        end
    end

    assign data_r       = data_r_q;
    assign data_r_valid = valid_q;
    assign full         = full_q;
    assign empty        = empty_q;
    assign almost_full  = afull_q;
    assign almost_empty = aempty_q;
    assign count        = count_q;
    assign overflow     = ovf_q;
    assign underflow    = udf_q;

endmodule

// File: tb/tb_sync_fifo_ctrl.sv
// Directed bench for sync_fifo_ctrl with default parameters (16 x 8).
module tb_sync_fifo_ctrl;

    logic       clk;
    logic       rst;
    logic       wr_en;
    logic [7:0] data_w;
    logic       rd_en;
    logic [7:0] data_r;
    logic       data_r_valid;
    logic       full;
    logic       empty;
    logic       almost_full;
    logic       almost_empty;
    logic [4:0] count;
    logic       overflow;
    logic       underflow;
    logic       clr_err;

    int checks   = 0;
    int failures = 0;

    sync_fifo_ctrl dut (
        .clk          (clk),
        .rst          (rst),
        .wr_en        (wr_en),
        .data_w       (data_w),
        .rd_en        (rd_en),
        .data_r       (data_r),
        .data_r_valid (data_r_valid),
        .full         (full),
        .empty        (empty),
        .almost_full  (almost_full),
        .almost_empty (almost_empty),
        .count        (count),
        .overflow     (overflow),
        .underflow    (underflow),
        .clr_err      (clr_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Apply one cycle of inputs, then sample 1 time unit after the edge.
    task automatic cyc(input logic w, input logic [7:0] d, input logic r, input logic c);
        wr_en   = w;
        data_w  = d;
        rd_en   = r;
        clr_err = c;
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst = 1'b1; wr_en = 1'b0; data_w = 8'h00; rd_en = 1'b0; clr_err = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        repeat (3) cyc(0, 8'h00, 0, 0);
        chk("rst_empty",  empty, 1);
        chk("rst_aempty", almost_empty, 1);
        chk("rst_full",   full, 0);
        chk("rst_afull",  almost_full, 0);
        chk("rst_count",  count, 0);
        chk("rst_data",   data_r, 0);
        chk("rst_valid",  data_r_valid, 0);
        chk("rst_ovf",    overflow, 0);
        chk("rst_udf",    underflow, 0);

        // 15 writes then 15 reads
        for (int i = 0; i < 15; i++) begin
            cyc(1, 8'h11 + 8'(i), 0, 0);
            chk("w15_count", count, i + 1);
            chk("w15_afull", almost_full, (i + 1 >= 14) ? 1 : 0);
            chk("w15_aempty", almost_empty, (i + 1 <= 2) ? 1 : 0);
        end
        chk("w15_full", full, 0);
        for (int i = 0; i < 15; i++) begin
            cyc(0, 8'h00, 1, 0);
            chk("r15_data",  data_r, 8'h11 + 8'(i));
            chk("r15_valid", data_r_valid, 1);
            chk("r15_count", count, 14 - i);
        end
        cyc(0, 8'h00, 0, 0);
        chk("r15_valid_drop", data_r_valid, 0);
        chk("r15_data_hold",  data_r, 8'h1F);
        chk("r15_empty",      empty, 1);

        // fill, overflow, drain
        for (int i = 0; i < 16; i++) cyc(1, 8'h20 + 8'(i), 0, 0);
        chk("fill_full",  full, 1);
        chk("fill_count", count, 16);
        chk("fill_ovf",   overflow, 0);
        cyc(1, 8'hAA, 0, 0);
        chk("ovf_full",  full, 1);
        chk("ovf_count", count, 16);
        chk("ovf_flag",  overflow, 1);
        cyc(1, 8'hBB, 1, 0);
        chk("fullrw_data",  data_r, 8'h20);
        chk("fullrw_count", count, 15);
        chk("fullrw_full",  full, 0);
        for (int i = 1; i < 16; i++) begin
            cyc(0, 8'h00, 1, 0);
            chk("drain_data", data_r, 8'h20 + 8'(i));
        end
        chk("drain_empty", empty, 1);
        chk("drain_ovf_sticky", overflow, 1);
        cyc(0, 8'h00, 0, 1);
        chk("clr_ovf", overflow, 0);

        // simultaneous write/read while empty
        cyc(1, 8'h5C, 1, 0);
        chk("erw_count", count, 1);
        chk("erw_valid", data_r_valid, 0);
        chk("erw_udf",   underflow, 1);
        cyc(0, 8'h00, 1, 0);
        chk("erw_data",  data_r, 8'h5C);
        chk("erw_valid2", data_r_valid, 1);
        chk("erw_count2", count, 0);
        cyc(0, 8'h00, 1, 1);
        chk("clr_vs_set_udf", underflow, 1);
        cyc(0, 8'h00, 0, 1);
        chk("clr_udf", underflow, 0);

        // steady state at count 8 with pointer wrap
        for (int i = 0; i < 8; i++) cyc(1, 8'h40 + 8'(i), 0, 0);
        chk("c8_count", count, 8);
        for (int j = 0; j < 20; j++) begin
            cyc(1, 8'h48 + 8'(j), 1, 0);
            chk("c8_data",  data_r, 8'h40 + 8'(j));
            chk("c8_count", count, 8);
        end
        cyc(0, 8'h00, 1, 0);
        chk("pre_rst_data", data_r, 8'h54);
        cyc(0, 8'h00, 1, 0);
        chk("pre_rst_data", data_r, 8'h55);
        chk("pre_rst_count", count, 6);

        // asynchronous reset with no clock edge
        wr_en = 1'b1; data_w = 8'h99;
        #1 rst = 1'b1;
        #1;
        chk("arst_count", count, 0);
        chk("arst_empty", empty, 1);
        chk("arst_aempty", almost_empty, 1);
        chk("arst_data",  data_r, 0);
        chk("arst_valid", data_r_valid, 0);
        wr_en = 1'b0;
        @(posedge clk);
        #1 rst = 1'b0;
        cyc(1, 8'h01, 0, 0);
        chk("post_rst_count", count, 1);
        cyc(0, 8'h00, 1, 0);
        chk("post_rst_data",  data_r, 8'h01);
        chk("post_rst_valid", data_r_valid, 1);
        chk("post_rst_empty", empty, 1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
